// File: rtl/csr_file_m.sv
// Machine-mode CSR file: CSRRW/RS/RC access, trap entry with vectored mtvec,
// mret restore, 64-bit mcycle/minstret and illegal-access detection.
module csr_file_m #(
  parameter int          NUM_LOCAL_INT = 4,
  parameter logic [31:0] MTVEC_RESET   = 32'h0,
  parameter int          HAS_INSTRET   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     csr_valid,
  input  logic [1:0]               csr_op,
  input  logic [11:0]              csr_addr,
  input  logic [31:0]              csr_wdata,
  output logic [31:0]              csr_rdata,
  output logic                     csr_illegal,
  input  logic                     instr_retire,
  input  logic                     exc_valid,
  input  logic [3:0]               exc_cause,
  input  logic [31:0]              pc,
  input  logic                     mret_instr,
  input  logic                     timer_int,
  input  logic                     soft_int,
  input  logic                     ext_int,
  input  logic [NUM_LOCAL_INT-1:0] local_int,
  output logic                     redirect,
  output logic [31:0]              redirect_pc
);

  localparam logic [11:0] A_MSTATUS  = 12'h300, A_MISA     = 12'h301, A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305, A_MSCRATCH = 12'h340, A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342, A_MIP      = 12'h344, A_MHARTID  = 12'hF14;
  localparam logic [11:0] A_MCYCLE   = 12'hB00, A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80, A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE    = 12'hC00, A_INSTRET  = 12'hC02;
  localparam logic [11:0] A_CYCLEH   = 12'hC80, A_INSTRETH = 12'hC82;

  localparam logic [31:0] MISA_VAL = 32'h4000_0100;
  localparam logic [31:0] MIE_MASK = (((32'd1 << NUM_LOCAL_INT) - 32'd1) << 16) | 32'h0000_0888;

  logic        mst_mie, mst_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0] mcycle_q, minstret_q;

  logic [15:0] li_pad;
  logic [31:0] mip, pend, mstatus_rd, rd_raw, wval, base;
  logic [63:0] cyc_nxt, ins_nxt;
  logic [4:0]  irq_code, cause_code;
  logic        impl, no_wr, ro, wr_req, bad_wr, illegal;
  logic        take_irq, trap, we;

  always_comb begin
    li_pad = '0;
    for (int i = 0; i < NUM_LOCAL_INT; i++) li_pad[i] = local_int[i];
  end

  assign mip        = {li_pad, 4'b0, ext_int, 3'b0, timer_int, 3'b0, soft_int, 3'b0};
  assign pend       = mip & mie_q;
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};

  // Lowest priority assigned first so higher-priority sources override.
  always_comb begin
    irq_code = '0;
    for (int i = 0; i < 16; i++) if (pend[16+i]) irq_code = 5'(16 + i);
    if (pend[7])  irq_code = 5'd7;
    if (pend[3])  irq_code = 5'd3;
    if (pend[11]) irq_code = 5'd11;
  end

  assign take_irq   = mst_mie & (|pend) & ~exc_valid;
  assign trap       = exc_valid | take_irq;
  assign cause_code = exc_valid ? {1'b0, exc_cause} : irq_code;
  assign base       = {mtvec_q[31:2], 2'b00};

  assign redirect = ~reset & (trap | mret_instr);
  always_comb begin
    if (trap) redirect_pc = (take_irq && mtvec_q[1:0] == 2'b01) ? base + {25'b0, cause_code, 2'b00} : base;
    else      redirect_pc = mepc_q;
  end

  always_comb begin
    rd_raw = '0;
    impl   = 1'b1;
    no_wr  = 1'b0;
    case (csr_addr)
      A_MSTATUS:              rd_raw = mstatus_rd;
      A_MISA:                 rd_raw = MISA_VAL;
      A_MIE:                  rd_raw = mie_q;
      A_MTVEC:                rd_raw = mtvec_q;
      A_MSCRATCH:             rd_raw = mscratch_q;
      A_MEPC:                 rd_raw = mepc_q;
      A_MCAUSE:               rd_raw = mcause_q;
      A_MIP:                  rd_raw = mip;
      A_MHARTID:              rd_raw = '0;
      A_MCYCLE, A_CYCLE:      rd_raw = mcycle_q[31:0];
      A_MCYCLEH, A_CYCLEH:    rd_raw = mcycle_q[63:32];
      A_MINSTRET, A_INSTRET: begin
        rd_raw = minstret_q[31:0];
        no_wr  = (HAS_INSTRET == 0);
      end
      A_MINSTRETH, A_INSTRETH: begin
        rd_raw = minstret_q[63:32];
        no_wr  = (HAS_INSTRET == 0);
      end
      default:                impl = 1'b0;
    endcase
  end

  // RS/RC with a zero operand never modifies state, so it is allowed on read-only CSRs.
  assign ro      = (csr_addr[11:10] == 2'b11);
  assign wr_req  = csr_valid & (csr_op != 2'b00);
  assign bad_wr  = (ro | no_wr) & wr_req & ~((csr_op != 2'b01) & (csr_wdata == 32'h0));
  assign illegal = csr_valid & (~impl | bad_wr);

  assign csr_illegal = ~reset & illegal;
  assign csr_rdata   = illegal ? 32'h0 : rd_raw;

  always_comb begin
    case (csr_op)
      2'b01:   wval = csr_wdata;
      2'b10:   wval = rd_raw | csr_wdata;
      2'b11:   wval = rd_raw & ~csr_wdata;
      default: wval = rd_raw;
    endcase
  end

  assign we = wr_req & ~illegal & ~trap & ~mret_instr;

  // A written half replaces its own increment; the other half still sees the carry.
  always_comb begin
    cyc_nxt = mcycle_q + 64'd1;
    if (we && csr_addr == A_MCYCLE)  cyc_nxt[31:0]  = wval;
    if (we && csr_addr == A_MCYCLEH) cyc_nxt[63:32] = wval;
    ins_nxt = minstret_q + {63'b0, instr_retire & ~exc_valid};
    if (we && csr_addr == A_MINSTRET)  ins_nxt[31:0]  = wval;
    if (we && csr_addr == A_MINSTRETH) ins_nxt[63:32] = wval;
    if (HAS_INSTRET == 0) ins_nxt = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= cyc_nxt;
      minstret_q <= ins_nxt;
      if (trap) begin
        mepc_q   <= pc & ~32'h3;
        mcause_q <= {~exc_valid, 26'b0, cause_code};
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (mret_instr) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (we) begin
        case (csr_addr)
          A_MSTATUS: begin
            mst_mie  <= wval[3];
            mst_mpie <= wval[7];
          end
          A_MIE:      mie_q      <= wval & MIE_MASK;
          A_MTVEC:    mtvec_q    <= {wval[31:2], 1'b0, wval[1:0] == 2'b01};
          A_MSCRATCH: mscratch_q <= wval;
          A_MEPC:     mepc_q     <= wval & ~32'h3;
          A_MCAUSE:   mcause_q   <= wval;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_file_m.sv
// Scoreboard bench for csr_file_m: expected values are queued as stimulus is
// driven and popped when the DUT output is sampled on the falling edge.
module tb_csr_file_m;

  localparam logic [1:0] NOP = 2'b00, RW = 2'b01, RS = 2'b10, RC = 2'b11;

  logic        clock = 1'b0, reset = 1'b1;
  logic        csr_valid, instr_retire, exc_valid, mret_instr;
  logic        timer_int, soft_int, ext_int, csr_illegal, redirect;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, pc, redirect_pc;
  logic [3:0]  exc_cause, local_int;

  int pass_cnt = 0, total_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] scratch_model;

  always #5 clock = ~clock;

  csr_file_m #(.NUM_LOCAL_INT(4), .MTVEC_RESET(32'h0), .HAS_INSTRET(1)) dut (
    .clock(clock), .reset(reset), .csr_valid(csr_valid), .csr_op(csr_op),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .instr_retire(instr_retire), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .pc(pc), .mret_instr(mret_instr), .timer_int(timer_int),
    .soft_int(soft_int), .ext_int(ext_int), .local_int(local_int),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  task automatic clr;
    csr_valid = 0; csr_op = NOP; csr_addr = '0; csr_wdata = '0; instr_retire = 0;
    exc_valid = 0; exc_cause = '0; pc = '0; mret_instr = 0;
    timer_int = 0; soft_int = 0; ext_int = 0; local_int = '0;
  endtask

  task automatic cyc;
    @(posedge clock); #1;
    clr;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_valid = 1; csr_op = op; csr_addr = a; csr_wdata = d;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cyc; csr(RW, a, d);
  endtask

  task automatic test_reset;
    logic [11:0] addrs [9] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF14, 12'hB00, 12'hB02};
    logic [31:0] exps  [9] = '{32'h1800, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] e;
    clr; reset = 1;
    csr(RW, 12'hC00, 32'h1); exc_valid = 1; exc_cause = 4'd2; mret_instr = 1;
    @(negedge clock);
    total_cnt++; if (redirect !== 1'b0) $display("FAIL reset_redirect: got %b want 0", redirect); else pass_cnt++;
    total_cnt++; if (csr_illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", csr_illegal); else pass_cnt++;
    clr;
    for (int i = 0; i < 9; i++) begin
      csr(NOP, addrs[i], 0); exp_q.push_back(exps[i]); #1;
      e = exp_q.pop_front(); total_cnt++;
      if (csr_rdata !== e) $display("FAIL reset_val[%h]: got %h want %h", addrs[i], csr_rdata, e); else pass_cnt++;
    end
    @(negedge clock); clr; reset = 0;
  endtask

  task automatic test_rw;
    logic [1:0]  ops [4] = '{RW, RS, RC, NOP};
    logic [31:0] dat [4] = '{32'hA5A5_0000, 32'h0000_00FF, 32'hA000_0000, 32'h0};
    logic [31:0] e;
    scratch_model = 32'h0;
    for (int i = 0; i < 4; i++) begin
      cyc; csr(ops[i], 12'h340, dat[i]);
      exp_q.push_back(scratch_model);
      case (ops[i])
        RW: scratch_model = dat[i];
        RS: scratch_model = scratch_model | dat[i];
        RC: scratch_model = scratch_model & ~dat[i];
        default: ;
      endcase
      @(negedge clock);
      e = exp_q.pop_front(); total_cnt++;
      if (csr_rdata !== e) $display("FAIL rw_old[%0d]: got %h want %h", i, csr_rdata, e); else pass_cnt++;
    end
    total_cnt++;
    if (csr_rdata !== 32'h05A5_00FF) $display("FAIL rw_final: got %h want 05a500ff", csr_rdata); else pass_cnt++;
  endtask

  task automatic test_warl;
    logic [11:0] addrs [8] = '{12'h341, 12'h305, 12'h305, 12'h305, 12'h304, 12'h300, 12'h300, 12'h304};
    logic [31:0] dat   [8] = '{32'h1237, 32'h103, 32'h102, 32'h201, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    logic [31:0] exps  [8] = '{32'h1234, 32'h100, 32'h100, 32'h201, 32'h000F_0888, 32'h1888, 32'h1800, 32'h0};
    logic [31:0] e;
    for (int i = 0; i < 8; i++) begin
      wr(addrs[i], dat[i]);
      exp_q.push_back(exps[i]);
      cyc; csr(NOP, addrs[i], 0);
      @(negedge clock);
      e = exp_q.pop_front(); total_cnt++;
      if (csr_rdata !== e) $display("FAIL warl[%0d]: got %h want %h", i, csr_rdata, e); else pass_cnt++;
    end
  endtask

  task automatic test_illegal;
    logic [31:0] c0, e;
    cyc; csr(NOP, 12'hC00, 0); @(negedge clock); c0 = csr_rdata;
    total_cnt++; if (csr_illegal !== 1'b0) $display("FAIL ill_read: got %b want 0", csr_illegal); else pass_cnt++;
    cyc; csr(RW, 12'hC00, 32'h0); @(negedge clock);
    total_cnt++; if (csr_illegal !== 1'b1) $display("FAIL ill_rw_ro: got %b want 1", csr_illegal); else pass_cnt++;
    total_cnt++; if (csr_rdata !== 32'h0) $display("FAIL ill_rdata: got %h want 0", csr_rdata); else pass_cnt++;
    cyc; csr(RS, 12'hC00, 32'h0); exp_q.push_back(c0 + 32'd2); @(negedge clock);
    total_cnt++; if (csr_illegal !== 1'b0) $display("FAIL ill_rs0: got %b want 0", csr_illegal); else pass_cnt++;
    e = exp_q.pop_front(); total_cnt++;
    if (csr_rdata !== e) $display("FAIL ill_count: got %h want %h", csr_rdata, e); else pass_cnt++;
    cyc; csr(RC, 12'hC00, 32'h5); @(negedge clock);
    total_cnt++; if (csr_illegal !== 1'b1) $display("FAIL ill_rc_ro: got %b want 1", csr_illegal); else pass_cnt++;
    cyc; csr(NOP, 12'h7C0, 0); @(negedge clock);
    total_cnt++; if (csr_illegal !== 1'b1) $display("FAIL ill_unimpl: got %b want 1", csr_illegal); else pass_cnt++;
  endtask

  task automatic test_vector;
    logic [11:0] addrs [3] = '{12'h341, 12'h342, 12'h300};
    logic [31:0] exps  [3] = '{32'h40, 32'h8000_0007, 32'h1880};
    logic [31:0] e;
    wr(12'h305, 32'h101); wr(12'h304, 32'h80); wr(12'h300, 32'h8);
    cyc; pc = 32'h40; timer_int = 1; exp_q.push_back(32'h11C); @(negedge clock);
    total_cnt++; if (redirect !== 1'b1) $display("FAIL vec_redirect: got %b want 1", redirect); else pass_cnt++;
    e = exp_q.pop_front(); total_cnt++;
    if (redirect_pc !== e) $display("FAIL vec_pc: got %h want %h", redirect_pc, e); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      cyc; csr(NOP, addrs[i], 0); timer_int = 1; exp_q.push_back(exps[i]); @(negedge clock);
      e = exp_q.pop_front(); total_cnt++;
      if (csr_rdata !== e) $display("FAIL vec_state[%h]: got %h want %h", addrs[i], csr_rdata, e); else pass_cnt++;
      if (i == 0) begin
        total_cnt++; if (redirect !== 1'b0) $display("FAIL vec_masked: got %b want 0", redirect); else pass_cnt++;
      end
    end
  endtask

  task automatic test_mret;
    logic [31:0] e;
    cyc; mret_instr = 1; csr(RW, 12'h340, 32'hDEAD_BEEF); exp_q.push_back(32'h40); @(negedge clock);
    total_cnt++; if (redirect !== 1'b1) $display("FAIL mret_redirect: got %b want 1", redirect); else pass_cnt++;
    e = exp_q.pop_front(); total_cnt++;
    if (redirect_pc !== e) $display("FAIL mret_pc: got %h want %h", redirect_pc, e); else pass_cnt++;
    cyc; csr(NOP, 12'h300, 0); @(negedge clock);
    total_cnt++; if (csr_rdata !== 32'h1888) $display("FAIL mret_mstatus: got %h want 00001888", csr_rdata); else pass_cnt++;
    cyc; csr(NOP, 12'h340, 0); exp_q.push_back(scratch_model); @(negedge clock);
    e = exp_q.pop_front(); total_cnt++;
    if (csr_rdata !== e) $display("FAIL mret_drop_write: got %h want %h", csr_rdata, e); else pass_cnt++;
  endtask

  task automatic test_priority;
    logic [6:0] srcs [4] = '{7'b101_0100, 7'b011_0000, 7'b001_0110, 7'b000_0110};
    logic [4:0] codes [4] = '{5'd11, 5'd3, 5'd7, 5'd18};
    logic [31:0] e;
    wr(12'h304, 32'h0006_0888);
    cyc; ext_int = 1; timer_int = 1; local_int = 4'b0100; exc_valid = 1; exc_cause = 4'd11; pc = 32'h80;
    exp_q.push_back(32'h100); @(negedge clock);
    e = exp_q.pop_front(); total_cnt++;
    if (redirect_pc !== e) $display("FAIL prio_exc_pc: got %h want %h", redirect_pc, e); else pass_cnt++;
    cyc; ext_int = 1; timer_int = 1; local_int = 4'b0100; @(negedge clock);
    total_cnt++; if (redirect !== 1'b0) $display("FAIL prio_masked: got %b want 0", redirect); else pass_cnt++;
    cyc; csr(NOP, 12'h342, 0); @(negedge clock);
    total_cnt++; if (csr_rdata !== 32'hB) $display("FAIL prio_mcause: got %h want 0000000b", csr_rdata); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      cyc; mret_instr = 1;
      cyc; {ext_int, soft_int, timer_int, local_int} = srcs[i]; pc = 32'h200;
      exp_q.push_back(32'h100 + {25'b0, codes[i], 2'b00}); @(negedge clock);
      e = exp_q.pop_front(); total_cnt++;
      if (redirect_pc !== e) $display("FAIL prio_vec[%0d]: got %h want %h", i, redirect_pc, e); else pass_cnt++;
      cyc; csr(NOP, 12'h342, 0); exp_q.push_back({1'b1, 26'b0, codes[i]}); @(negedge clock);
      e = exp_q.pop_front(); total_cnt++;
      if (csr_rdata !== e) $display("FAIL prio_cause[%0d]: got %h want %h", i, csr_rdata, e); else pass_cnt++;
    end
  endtask

  task automatic test_instret;
    logic [31:0] v0, e;
    cyc; instr_retire = 1; csr(NOP, 12'hB02, 0); @(negedge clock); v0 = csr_rdata;
    cyc; instr_retire = 1; exc_valid = 1; exc_cause = 4'd2;
    cyc; instr_retire = 1;
    cyc; csr(NOP, 12'hB02, 0); exp_q.push_back(v0 + 32'd2); @(negedge clock);
    e = exp_q.pop_front(); total_cnt++;
    if (csr_rdata !== e) $display("FAIL instret: got %h want %h", csr_rdata, e); else pass_cnt++;
    csr(NOP, 12'hC02, 0); #1;
    total_cnt++; if (csr_rdata !== e) $display("FAIL instret_ro: got %h want %h", csr_rdata, e); else pass_cnt++;
  endtask

  task automatic test_carry;
    logic [31:0] h0, e;
    cyc; csr(NOP, 12'hB80, 0); @(negedge clock); h0 = csr_rdata;
    wr(12'hB00, 32'hFFFF_FFFF);
    cyc; csr(NOP, 12'hB00, 0); @(negedge clock);
    total_cnt++; if (csr_rdata !== 32'hFFFF_FFFF) $display("FAIL carry_lo_wr: got %h want ffffffff", csr_rdata); else pass_cnt++;
    cyc; csr(NOP, 12'hB00, 0); @(negedge clock);
    total_cnt++; if (csr_rdata !== 32'h0) $display("FAIL carry_lo_wrap: got %h want 0", csr_rdata); else pass_cnt++;
    cyc; csr(NOP, 12'hB80, 0); exp_q.push_back(h0 + 32'd1); @(negedge clock);
    e = exp_q.pop_front(); total_cnt++;
    if (csr_rdata !== e) $display("FAIL carry_hi: got %h want %h", csr_rdata, e); else pass_cnt++;
    wr(12'hB80, 32'h1234);
    cyc; csr(NOP, 12'hB80, 0); @(negedge clock);
    total_cnt++; if (csr_rdata !== 32'h1234) $display("FAIL hi_write: got %h want 00001234", csr_rdata); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [11:0] addrs [4] = '{12'h340, 12'h341, 12'h342, 12'h300};
    logic [31:0] exps  [4] = '{32'h0, 32'h0, 32'h0, 32'h1800};
    logic [31:0] e;
    cyc; exc_valid = 1; exc_cause = 4'd5; pc = 32'h300; csr(RW, 12'h340, 32'h1111);
    #2 reset = 1; #1;
    total_cnt++; if (redirect !== 1'b0) $display("FAIL mid_redirect: got %b want 0", redirect); else pass_cnt++;
    @(posedge clock); #1; clr; #2 reset = 0;
    for (int i = 0; i < 4; i++) begin
      csr(NOP, addrs[i], 0); exp_q.push_back(exps[i]); #1;
      e = exp_q.pop_front(); total_cnt++;
      if (csr_rdata !== e) $display("FAIL mid_state[%h]: got %h want %h", addrs[i], csr_rdata, e); else pass_cnt++;
    end
  endtask

  initial begin
    clr;
    test_reset;
    test_rw;
    test_warl;
    test_illegal;
    test_vector;
    test_mret;
    test_priority;
    test_instret;
    test_carry;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
